// File: rtl/ex_stage_ctrl.sv
// EX-stage sequencer for the 5-stage MIPS core: DX/XM/MW slot tracking, forwarding, hazards.
// Optional stall/hold cycle counter enabled by defining EX_STALL_CNT_EN.
module ex_stage_ctrl #(
    parameter int NREG_BITS = 5,
    parameter int CTR_BITS  = 3,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [5:0]           id_opcode,
    input  logic [5:0]           id_funct,
    input  logic [NREG_BITS-1:0] id_rs,
    input  logic [NREG_BITS-1:0] id_rt,
    input  logic [NREG_BITS-1:0] id_rd,
    input  logic                 id_use_rs,
    input  logic                 id_use_rt,
    input  logic                 id_wen,
    input  logic                 flush_req,
    input  logic                 mem_hold,
    output logic                 id_stall,
    output logic [NREG_BITS-1:0] dx_rd,
    output logic [CTR_BITS-1:0]  ex_alu_ctr,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic                 ex_illegal,
`ifdef EX_STALL_CNT_EN
    output logic [CNT_W-1:0]     stall_cnt,
    input  logic                 cnt_clr,
`endif
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t state_q, state_nxt;

    logic                 dx_valid, dx_wen, dx_is_load, dx_use_rs, dx_use_rt;
    logic [NREG_BITS-1:0] dx_rs, dx_rt;
    logic                 xm_valid, xm_wen, xm_is_load;
    logic [NREG_BITS-1:0] xm_rd;
    // MW only feeds forwarding; its load flag has no consumer and is not kept.
    logic                 mw_valid, mw_wen;
    logic [NREG_BITS-1:0] mw_rd;

    logic [CTR_BITS-1:0]  dec_ctr;
    logic                 dec_illegal;
    logic                 dec_is_load;
    logic                 load_use;

    function automatic logic slot_hit(input logic v, input logic w,
                                      input logic [NREG_BITS-1:0] rd,
                                      input logic [NREG_BITS-1:0] r);
        return v && w && (rd != '0) && (rd == r);
    endfunction

    always_comb begin
        dec_ctr     = '0;
        dec_illegal = 1'b0;
        case (id_opcode)
            6'h00: begin
                case (id_funct)
                    6'h20:   dec_ctr = CTR_BITS'(0);
                    6'h22:   dec_ctr = CTR_BITS'(1);
                    6'h2A:   dec_ctr = CTR_BITS'(2);
                    default: dec_illegal = 1'b1;
                endcase
            end
            6'h23, 6'h2B, 6'h08: dec_ctr = CTR_BITS'(0);
            default:             dec_illegal = 1'b1;
        endcase
    end

    assign dec_is_load = (id_opcode == 6'h23);

    assign load_use = id_valid && dx_is_load &&
                      ((id_use_rs && slot_hit(dx_valid, dx_wen, dx_rd, id_rs)) ||
                       (id_use_rt && slot_hit(dx_valid, dx_wen, dx_rd, id_rt)));

    // State records which branch the last edge took.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_RUN;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = S_RUN;
        if (mem_hold)       state_nxt = S_HOLD;
        else if (flush_req) state_nxt = S_FLUSH;
        else if (load_use)  state_nxt = S_STALL;
    end

    always_comb begin
        state    = state_q;
        id_stall = !rst && ((state_nxt == S_STALL) || (state_nxt == S_HOLD));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx_valid   <= 1'b0;
            dx_wen     <= 1'b0;
            dx_is_load <= 1'b0;
            dx_use_rs  <= 1'b0;
            dx_use_rt  <= 1'b0;
            dx_rs      <= '0;
            dx_rt      <= '0;
            dx_rd      <= '0;
            ex_alu_ctr <= '0;
            ex_illegal <= 1'b0;
            xm_valid   <= 1'b0;
            xm_wen     <= 1'b0;
            xm_is_load <= 1'b0;
            xm_rd      <= '0;
            mw_valid   <= 1'b0;
            mw_wen     <= 1'b0;
            mw_rd      <= '0;
        end else if (state_nxt != S_HOLD) begin
            xm_valid   <= dx_valid;
            xm_wen     <= dx_wen;
            xm_is_load <= dx_is_load;
            xm_rd      <= dx_rd;
            mw_valid   <= xm_valid;
            mw_wen     <= xm_wen;
            mw_rd      <= xm_rd;
            case (state_nxt)
                S_FLUSH: dx_valid <= 1'b0;
                S_STALL: begin
                    dx_valid   <= 1'b0;
                    dx_wen     <= 1'b0;
                    dx_is_load <= 1'b0;
                    dx_use_rs  <= 1'b0;
                    dx_use_rt  <= 1'b0;
                    dx_rs      <= '0;
                    dx_rt      <= '0;
                    dx_rd      <= '0;
                    ex_alu_ctr <= '0;
                    ex_illegal <= 1'b0;
                end
                default: begin
                    dx_valid   <= id_valid;
                    dx_wen     <= id_wen;
                    dx_is_load <= dec_is_load;
                    dx_use_rs  <= id_use_rs;
                    dx_use_rt  <= id_use_rt;
                    dx_rs      <= id_rs;
                    dx_rt      <= id_rt;
                    dx_rd      <= id_rd;
                    ex_alu_ctr <= dec_ctr;
                    ex_illegal <= dec_illegal;
                end
            endcase
        end
    end

    // A load still in XM has no data yet; the stall guarantees it is taken from MW instead.
    always_comb begin
        fwd_a = 2'd0;
        if (dx_use_rs && slot_hit(xm_valid, xm_wen, xm_rd, dx_rs) && !xm_is_load)
            fwd_a = 2'd1;
        else if (dx_use_rs && slot_hit(mw_valid, mw_wen, mw_rd, dx_rs))
            fwd_a = 2'd2;
    end

    always_comb begin
        fwd_b = 2'd0;
        if (dx_use_rt && slot_hit(xm_valid, xm_wen, xm_rd, dx_rt) && !xm_is_load)
            fwd_b = 2'd1;
        else if (dx_use_rt && slot_hit(mw_valid, mw_wen, mw_rd, dx_rt))
            fwd_b = 2'd2;
    end

`ifdef EX_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (cnt_clr)
            stall_cnt <= '0;
        else if (((state_nxt == S_STALL) || (state_nxt == S_HOLD)) && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// Randomized scoreboard bench for ex_stage_ctrl against an instruction-level pipeline model.
module tb_ex_stage_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [5:0] id_opcode = '0;
    logic [5:0] id_funct = '0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_wen = 1'b0;
    logic       flush_req = 1'b0, mem_hold = 1'b0;
    logic       id_stall;
    logic [4:0] dx_rd;
    logic [2:0] ex_alu_ctr;
    logic [1:0] fwd_a, fwd_b, state;
    logic       ex_illegal;
`ifdef EX_STALL_CNT_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] stall_cnt;
`endif

    ex_stage_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_opcode  (id_opcode),
        .id_funct   (id_funct),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_wen     (id_wen),
        .flush_req  (flush_req),
        .mem_hold   (mem_hold),
        .id_stall   (id_stall),
        .dx_rd      (dx_rd),
        .ex_alu_ctr (ex_alu_ctr),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .ex_illegal (ex_illegal),
`ifdef EX_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
        .cnt_clr    (cnt_clr),
`endif
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v; bit [5:0] op, fn; bit [4:0] rs, rt, rd; bit urs, urt, wen;
    } id_t;

    // An instruction as it sits in a pipeline slot.
    typedef struct {
        bit v, w, ld, urs, urt, ill; bit [4:0] rd, rs, rt; int ctr;
    } ins_t;

    typedef struct {
        int stall, fa, fb, st, rd, ctr, ill, cnt;
    } exp_t;

    localparam int RUN = 0, STALL = 1, FLUSH = 2, HOLD = 3;

    ins_t dx, xm, mw;
    int   last_act, cnt_m;
    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   last_stall = 0;

    function automatic bit hits(input ins_t s, input bit [4:0] r);
        return s.v && s.w && (s.rd != 0) && (s.rd == r);
    endfunction

    function automatic int fwd_of(input bit use_r, input bit [4:0] r);
        if (use_r && hits(xm, r) && !xm.ld) return 1;
        if (use_r && hits(mw, r)) return 2;
        return 0;
    endfunction

    function automatic ins_t to_ins(input id_t i);
        ins_t s;
        s = '{default: 0};
        s.v = i.v; s.w = i.wen; s.rd = i.rd; s.rs = i.rs; s.rt = i.rt;
        s.urs = i.urs; s.urt = i.urt; s.ld = (i.op == 6'h23);
        if (i.op == 6'h00) begin
            if (i.fn == 6'h20)      s.ctr = 0;
            else if (i.fn == 6'h22) s.ctr = 1;
            else if (i.fn == 6'h2A) s.ctr = 2;
            else                    s.ill = 1;
        end else if (!(i.op == 6'h23 || i.op == 6'h2B || i.op == 6'h08)) begin
            s.ill = 1;
        end
        return s;
    endfunction

    function automatic id_t mk(input bit [5:0] op, input bit [5:0] fn,
                               input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd);
        id_t i;
        i.v = 1; i.op = op; i.fn = fn; i.rs = rs; i.rt = rt; i.rd = rd;
        i.urs = 1; i.urt = (op == 6'h00) || (op == 6'h2B); i.wen = (op != 6'h2B);
        return i;
    endfunction

    function automatic id_t nop();
        id_t i;
        i = mk(6'h00, 6'h20, 0, 0, 0);
        i.v = 0; i.wen = 0;
        return i;
    endfunction

    // One clock: drive inputs, record what the DUT must show, then advance the model.
    task automatic cycle(input id_t i, input bit r, input bit fl, input bit hold, input bit clr);
        exp_t e;
        int   act;
        bit   lu;
        @(negedge clk);
        rst = r; id_valid = i.v; id_opcode = i.op; id_funct = i.fn;
        id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
        id_use_rs = i.urs; id_use_rt = i.urt; id_wen = i.wen;
        flush_req = fl; mem_hold = hold;
`ifdef EX_STALL_CNT_EN
        cnt_clr = clr;
`endif
        if (r) begin
            dx = '{default: 0}; xm = '{default: 0}; mw = '{default: 0};
            last_act = RUN; cnt_m = 0;
        end
        lu  = i.v && dx.ld && ((i.urs && hits(dx, i.rs)) || (i.urt && hits(dx, i.rt)));
        act = hold ? HOLD : fl ? FLUSH : lu ? STALL : RUN;
        e.stall = (!r && (act == HOLD || act == STALL)) ? 1 : 0;
        e.fa  = fwd_of(dx.urs, dx.rs);
        e.fb  = fwd_of(dx.urt, dx.rt);
        e.st  = last_act;
        e.rd  = dx.rd;
        e.ctr = dx.ctr;
        e.ill = dx.ill;
        e.cnt = cnt_m;
        sb.push_back(e);
        last_stall = e.stall;
        if (!r) begin
            if (act != HOLD) begin
                mw = xm; xm = dx;
                if (act == FLUSH)      dx.v = 0;
                else if (act == STALL) dx = '{default: 0};
                else                   dx = to_ins(i);
            end
            last_act = act;
            if (clr) cnt_m = 0;
            else if ((act == HOLD || act == STALL) && cnt_m != 65535) cnt_m++;
        end
    endtask

    task automatic issue(input id_t i);
        cycle(i, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("id_stall", int'(id_stall), e.stall);
                chk("fwd_a", int'(fwd_a), e.fa);
                chk("fwd_b", int'(fwd_b), e.fb);
                chk("state", int'(state), e.st);
                chk("dx_rd", int'(dx_rd), e.rd);
                chk("ex_alu_ctr", int'(ex_alu_ctr), e.ctr);
                chk("ex_illegal", int'(ex_illegal), e.ill);
`ifdef EX_STALL_CNT_EN
                chk("stall_cnt", int'(stall_cnt), e.cnt);
`endif
            end
        end
    end

    initial begin : stim
        bit [5:0] op_tab [8];
        bit [5:0] fn_tab [8];
        id_t cur;
        int  k;
        op_tab = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h3F, 6'h0D};
        fn_tab = '{6'h20, 6'h22, 6'h2A, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

        cycle(nop(), 1, 0, 0, 0);
        cycle(nop(), 1, 0, 0, 0);
        // reset while DX holds lw r8
        issue(mk(6'h23, 0, 1, 0, 8));
        cycle(nop(), 1, 0, 0, 0);
        issue(nop());
        // decode: add, sub, slt, lw, illegal
        issue(mk(6'h00, 6'h20, 1, 2, 10));
        issue(mk(6'h00, 6'h22, 1, 2, 11));
        issue(mk(6'h00, 6'h2A, 1, 2, 12));
        issue(mk(6'h23, 6'h00, 1, 0, 13));
        issue(mk(6'h3F, 6'h00, 1, 2, 14));
        issue(nop()); issue(nop()); issue(nop());
        // forwarding XM, then MW, then r0
        issue(mk(6'h00, 6'h20, 1, 2, 3));
        issue(mk(6'h00, 6'h22, 3, 3, 4));
        issue(mk(6'h00, 6'h20, 1, 2, 3));
        issue(nop());
        issue(mk(6'h00, 6'h22, 3, 3, 4));
        issue(mk(6'h00, 6'h20, 1, 2, 0));
        issue(mk(6'h00, 6'h22, 0, 0, 4));
        issue(nop()); issue(nop());
        // load-use: one stall, consumer re-presented
        issue(mk(6'h23, 0, 1, 0, 5));
        issue(mk(6'h00, 6'h20, 5, 1, 6));
        issue(mk(6'h00, 6'h20, 5, 1, 6));
        issue(nop()); issue(nop());
        // flush beats load-use
        issue(mk(6'h23, 0, 1, 0, 5));
        cycle(mk(6'h00, 6'h20, 5, 1, 6), 0, 1, 0, 0);
        issue(mk(6'h00, 6'h20, 5, 5, 7));
        issue(nop()); issue(nop());
        // hold for 3 cycles during a load-use, then stall, then run
        cycle(nop(), 0, 0, 0, 1);
        issue(mk(6'h23, 0, 1, 0, 5));
        for (int h = 0; h < 3; h++) cycle(mk(6'h00, 6'h20, 5, 1, 6), 0, 0, 1, 0);
        issue(mk(6'h00, 6'h20, 5, 1, 6));
        issue(mk(6'h00, 6'h20, 5, 1, 6));
        issue(nop()); issue(nop());

        cur = nop();
        for (int n = 0; n < 3000; n++) begin
            if (!last_stall) begin
                k = $urandom_range(0, 7);
                cur = mk(op_tab[k], ($urandom_range(0, 15) == 0) ? 6'($urandom) : fn_tab[k],
                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)));
                cur.v = ($urandom_range(0, 5) != 0);
                if ($urandom_range(0, 3) == 0) cur.urt = ~cur.urt;
            end
            cycle(cur, ($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0));
        end

        cycle(nop(), 0, 0, 0, 0);
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        #5;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain actual %0d required 0 pending entries", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
